// File: rtl/dshot_pkg.sv
// Shared types, constants and CRC helper for the DShot encoder.
// Optional command path is enabled by defining DSHOT_CMD_EN.
package dshot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BIT  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int DSHOT_MIN_THROTTLE = 48;
    localparam int DSHOT_MAX_VALUE    = 2047;
    localparam int DSHOT_FRAME_BITS   = 16;
    localparam int MIX_Q_FRAC         = 28;

    // XOR of the three nibbles of {value, telemetry}
    function automatic logic [3:0] dshot_crc(input logic [11:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

endpackage

// File: rtl/dshot_frame_builder.sv
// Combinational throttle-to-frame conversion: clamp, scale, CRC, assembly.
// With DSHOT_CMD_EN defined, a valid command 1..47 overrides the throttle path.
module dshot_frame_builder
    import dshot_pkg::*;
(
    input  logic [31:0] throttle,
    input  logic        telem,
`ifdef DSHOT_CMD_EN
    input  logic        cmd_valid,
    input  logic [5:0]  cmd,
`endif
    output logic [15:0] frame
);

    localparam logic [31:0] Q_ONE = 32'(1) << MIX_Q_FRAC;
    localparam logic [39:0] SCALE = 40'(DSHOT_MAX_VALUE - DSHOT_MIN_THROTTLE);

    logic        positive;
    logic [28:0] clamped;
    logic [10:0] scaled;
    logic [10:0] value;
    logic        telem_eff;
    logic [11:0] v;

    assign positive = !throttle[31] && (throttle != 32'd0);
    assign clamped  = (throttle > Q_ONE) ? Q_ONE[28:0] : throttle[28:0];
    // Truncating scale: 1.0 maps to exactly 1999, so value tops out at 2047
    assign scaled   = 11'((40'(clamped) * SCALE) >> MIX_Q_FRAC);

    always_comb begin
        value     = positive ? (11'(DSHOT_MIN_THROTTLE) + scaled) : 11'd0;
        telem_eff = telem;
`ifdef DSHOT_CMD_EN
        if (cmd_valid && (cmd != 6'd0) && (cmd < 6'(DSHOT_MIN_THROTTLE))) begin
            value     = {5'd0, cmd};
            telem_eff = 1'b1;
        end
`endif
    end

    assign v     = {value, telem_eff};
    assign frame = {v, dshot_crc(v)};

endmodule

// File: rtl/dshot_encoder.sv
// DShot frame serialiser: latches a throttle request, builds the frame and
// drives it MSB-first with a trailing gap. Optional DSHOT_CMD_EN adds commands.
module dshot_encoder
    import dshot_pkg::*;
#(
    parameter int BIT_CLKS = 80,
    parameter int T1H_CLKS = 60,
    parameter int T0H_CLKS = 30,
    parameter int GAP_CLKS = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        update,
    input  logic [31:0] throttle,
    input  logic        telem_req,
`ifdef DSHOT_CMD_EN
    input  logic        cmd_valid,
    input  logic [5:0]  cmd,
`endif
    output logic        busy,
    output logic        frame_done,
    output logic        dshot_out
);

    state_t      state, state_nxt;
    logic [15:0] tick, tick_nxt;
    logic [3:0]  bit_idx, bit_nxt;
    logic [15:0] frame_q, frame_nxt, built;
    logic [15:0] high_len;
    logic [31:0] thr_q;
    logic        telem_q;
    logic        dshot_d;
`ifdef DSHOT_CMD_EN
    logic        cmd_valid_q;
    logic [5:0]  cmd_q;
`endif

    dshot_frame_builder u_builder (
        .throttle  (thr_q),
        .telem     (telem_q),
`ifdef DSHOT_CMD_EN
        .cmd_valid (cmd_valid_q),
        .cmd       (cmd_q),
`endif
        .frame     (built)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick      <= '0;
            bit_idx   <= '0;
            frame_q   <= '0;
            dshot_out <= 1'b0;
            thr_q     <= '0;
            telem_q   <= 1'b0;
`ifdef DSHOT_CMD_EN
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
`endif
        end else begin
            state     <= state_nxt;
            tick      <= tick_nxt;
            bit_idx   <= bit_nxt;
            frame_q   <= frame_nxt;
            dshot_out <= dshot_d;
            if (state == IDLE && update) begin
                thr_q   <= throttle;
                telem_q <= telem_req;
`ifdef DSHOT_CMD_EN
                cmd_valid_q <= cmd_valid;
                cmd_q       <= cmd;
`endif
            end
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick;
        bit_nxt   = bit_idx;
        frame_nxt = frame_q;
        unique case (state)
            IDLE: begin
                tick_nxt = '0;
                bit_nxt  = '0;
                if (update) state_nxt = LOAD;
            end
            LOAD: begin
                frame_nxt = built;
                tick_nxt  = '0;
                bit_nxt   = '0;
                state_nxt = BIT;
            end
            BIT: begin
                if (tick == 16'(BIT_CLKS - 1)) begin
                    tick_nxt = '0;
                    if (bit_idx == 4'(DSHOT_FRAME_BITS - 1)) state_nxt = GAP;
                    else                                     bit_nxt   = bit_idx + 4'd1;
                end else begin
                    tick_nxt = tick + 16'd1;
                end
            end
            GAP: begin
                if (tick == 16'(GAP_CLKS - 1)) begin
                    tick_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    tick_nxt = tick + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Line level is computed from next-state values so the pad is driven by a flop
    always_comb begin
        high_len = frame_nxt[4'd15 - bit_nxt] ? 16'(T1H_CLKS) : 16'(T0H_CLKS);
        dshot_d  = (state_nxt == BIT) && (tick_nxt < high_len);
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == GAP) && (tick == 16'(GAP_CLKS - 1));

endmodule

// File: tb/tb_dshot_encoder.sv
// Table-driven bench for dshot_encoder; decodes the serial line and checks timing.
// Command vectors are exercised when DSHOT_CMD_EN is defined.
module tb_dshot_encoder;

    localparam int BIT_CLKS = 80;
    localparam int T1H_CLKS = 60;
    localparam int T0H_CLKS = 30;
    localparam int GAP_CLKS = 160;
    localparam int BIT_SPAN = 16 * BIT_CLKS;
    localparam int BODY     = BIT_SPAN + GAP_CLKS;

    typedef struct {
        string       name;
        logic [31:0] thr;
        logic        telem;
        logic        cmdValid;
        logic [5:0]  cmdVal;
        logic [15:0] expFrame;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        update = 1'b0;
    logic [31:0] throttle = '0;
    logic        telem_req = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [5:0]  cmd = '0;
    logic        busy, frame_done, dshot_out;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    dshot_encoder #(
        .BIT_CLKS(BIT_CLKS), .T1H_CLKS(T1H_CLKS),
        .T0H_CLKS(T0H_CLKS), .GAP_CLKS(GAP_CLKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .update     (update),
        .throttle   (throttle),
        .telem_req  (telem_req),
`ifdef DSHOT_CMD_EN
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
`endif
        .busy       (busy),
        .frame_done (frame_done),
        .dshot_out  (dshot_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drives a request in the current cycle; caller is positioned at a negedge
    task automatic applyStimulus(input vec_t v);
        throttle  = v.thr;
        telem_req = v.telem;
        cmd_valid = v.cmdValid;
        cmd       = v.cmdVal;
        update    = 1'b1;
    endtask

    // Sends one frame from the current negedge (cycle N) and leaves the bench
    // at the negedge of cycle N+1442, the first idle cycle. Pokes inject an
    // update (with altered inputs) at the given offset from cycle N+2.
    task automatic runFrame(input vec_t v, input int pokeA, input int pokeB);
        logic [15:0] decoded;
        int highCnt, shapeErr, gapErr, doneErr, busyErr, expLen;
        logic expBit, expLvl;
        decoded = '0; highCnt = 0; shapeErr = 0; gapErr = 0; doneErr = 0; busyErr = 0;
        applyStimulus(v);
        @(negedge clk);
        update = 1'b0;
        checkOutput({v.name, "_busy_accept"}, 32'(busy), 32'd1);
        checkOutput({v.name, "_low_load"}, 32'(dshot_out), 32'd0);
        @(negedge clk);
        checkOutput({v.name, "_first_high"}, 32'(dshot_out), 32'd1);
        for (int idx = 0; idx < BODY; idx++) begin
            if (idx < BIT_SPAN) begin
                expBit = v.expFrame[15 - idx / BIT_CLKS];
                expLen = expBit ? T1H_CLKS : T0H_CLKS;
                expLvl = ((idx % BIT_CLKS) < expLen);
                if (dshot_out !== expLvl) shapeErr++;
                if (dshot_out === 1'b1) highCnt++;
                if ((idx % BIT_CLKS) == BIT_CLKS - 1) begin
                    decoded = {decoded[14:0], (highCnt > (T0H_CLKS + T1H_CLKS) / 2)};
                    highCnt = 0;
                end
            end else if (dshot_out !== 1'b0) begin
                gapErr++;
            end
            if (frame_done !== (idx == BODY - 1)) doneErr++;
            if (busy !== 1'b1) busyErr++;
            if (idx == pokeA || idx == pokeB) begin
                update    = 1'b1;
                throttle  = 32'h0000_0000;
                telem_req = ~v.telem;
            end else begin
                update = 1'b0;
            end
            @(negedge clk);
        end
        update = 1'b0;
        checkOutput({v.name, "_frame"}, 32'(decoded), 32'(v.expFrame));
        checkOutput({v.name, "_shape"}, 32'(shapeErr), 32'd0);
        checkOutput({v.name, "_gap_low"}, 32'(gapErr), 32'd0);
        checkOutput({v.name, "_done_timing"}, 32'(doneErr), 32'd0);
        checkOutput({v.name, "_busy_frame"}, 32'(busyErr), 32'd0);
        checkOutput({v.name, "_idle_busy"}, 32'(busy), 32'd0);
        checkOutput({v.name, "_idle_done"}, 32'(frame_done), 32'd0);
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] t, input logic tl,
                                input logic cv, input logic [5:0] c, input logic [15:0] f);
        vec_t r;
        r.name = n; r.thr = t; r.telem = tl; r.cmdValid = cv; r.cmdVal = c; r.expFrame = f;
        return r;
    endfunction

    initial begin
        vec_t half;
        vecs.push_back(mk("half",      32'h0800_0000, 1'b0, 1'b0, 6'd0, 16'h82E4));
        vecs.push_back(mk("full",      32'h1000_0000, 1'b0, 1'b0, 6'd0, 16'hFFEE));
        vecs.push_back(mk("over_max",  32'h7FFF_FFFF, 1'b0, 1'b0, 6'd0, 16'hFFEE));
        vecs.push_back(mk("just_over", 32'h1000_0001, 1'b0, 1'b0, 6'd0, 16'hFFEE));
        vecs.push_back(mk("negative",  32'hFFFF_FFFB, 1'b1, 1'b0, 6'd0, 16'h0011));
        vecs.push_back(mk("zero_tlm",  32'h0000_0000, 1'b1, 1'b0, 6'd0, 16'h0011));
        vecs.push_back(mk("zero",      32'h0000_0000, 1'b0, 1'b0, 6'd0, 16'h0000));
        vecs.push_back(mk("quarter",   32'h0400_0000, 1'b1, 1'b0, 6'd0, 16'h4477));
        vecs.push_back(mk("tiny",      32'h0000_0001, 1'b0, 1'b0, 6'd0, 16'h0606));
`ifdef DSHOT_CMD_EN
        vecs.push_back(mk("cmd10",     32'h0800_0000, 1'b0, 1'b1, 6'd10, 16'h0154));
        vecs.push_back(mk("cmd47",     32'h0000_0000, 1'b0, 1'b1, 6'd47, 16'h05FA));
        vecs.push_back(mk("cmd48",     32'h0800_0000, 1'b0, 1'b1, 6'd48, 16'h82E4));
        vecs.push_back(mk("cmd0",      32'h0800_0000, 1'b0, 1'b1, 6'd0,  16'h82E4));
`endif
        half = vecs[0];

        #12;
        checkOutput("reset_dshot", 32'(dshot_out), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) runFrame(vecs[i], -1, -1);

        // Updates mid-bit and in the frame_done cycle must be dropped
        half.name = "poked";
        runFrame(half, 5 * BIT_CLKS + 3, BODY - 1);
        repeat (3) @(negedge clk);
        checkOutput("poke_no_queue", 32'(busy), 32'd0);

        // Back-to-back: second request lands on the first idle cycle
        half.name = "b2b_a";
        runFrame(half, -1, -1);
        half.name = "b2b_b";
        runFrame(half, -1, -1);

        // Reset during bit 7 while the line is high
        half.name = "rst";
        applyStimulus(half);
        @(negedge clk);
        update = 1'b0;
        repeat (2 + 7 * BIT_CLKS + 10 - 1) @(negedge clk);
        checkOutput("pre_reset_line", 32'(dshot_out), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_line", 32'(dshot_out), 32'd0);
        checkOutput("async_reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        half.name = "after_reset";
        runFrame(half, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
